// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO, issue register and result register placed
// around an external 4-bit combinational ALU, so that the ALU sits between
// two register boundaries.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   in_valid/in_ready command handshake (in_ready driven only by FIFO occupancy)
//   in_a, in_b        operands
//   in_op, in_mode    opcode and signed/unsigned mode
//   alu_a/b/op/mode   registered command presented to the ALU
//   alu_result/overflow  combinational ALU response
//   out_valid/out_ready  result handshake
//   out_result/overflow/op  captured result and the opcode that produced it
//   ovf_sticky, clr_sticky  overflow history flag and its clear
//   done_count        delivered results, wraps at 256
module alu_issue_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic [2:0] in_op,
   input  logic       in_mode,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   output logic       alu_mode,
   input  logic [3:0] alu_result,
   input  logic       alu_overflow,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_result,
   output logic       out_overflow,
   output logic [2:0] out_op,
   output logic       ovf_sticky,
   input  logic       clr_sticky,
   output logic [7:0] done_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic       mode;
   } cmd_t;

   cmd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt_c;
   logic             iss_valid;

   logic push_c;
   logic res_load_c;
   logic iss_load_c;
   cmd_t head_c;

   // Pipeline advance conditions; the result stage decides first, the
   // issue stage may refill in the same cycle it hands off.
   always_comb begin
      push_c      = in_valid && in_ready;
      res_load_c  = iss_valid && (!out_valid || out_ready);
      iss_load_c  = (count != '0) && (!iss_valid || res_load_c);
      head_c      = mem[rd_ptr];
      count_nxt_c = count;
      if (push_c && !iss_load_c) begin
         count_nxt_c = count + CNT_W'(1);
      end else if (!push_c && iss_load_c) begin
         count_nxt_c = count - CNT_W'(1);
      end
   end

   // FIFO storage; contents are only consumed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op, mode: in_mode};
      end
   end

   // FIFO pointers, occupancy and registered in_ready (full looks only at
   // the next count, so a popping cycle never re-opens a full FIFO early).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b1;
      end else begin
         if (push_c)     wr_ptr <= wr_ptr + PTR_W'(1);
         if (iss_load_c) rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_nxt_c;
         in_ready <= (count_nxt_c != CNT_W'(DEPTH));
      end
   end

   // Issue register; alu_* hold their last command when the stage empties.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iss_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         alu_mode  <= 1'b0;
      end else if (iss_load_c) begin
         iss_valid <= 1'b1;
         alu_a     <= head_c.a;
         alu_b     <= head_c.b;
         alu_op    <= head_c.op;
         alu_mode  <= head_c.mode;
      end else if (res_load_c) begin
         iss_valid <= 1'b0;
      end
   end

   // Result register; out_* hold after delivery.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_overflow <= 1'b0;
         out_op       <= '0;
      end else if (res_load_c) begin
         out_valid    <= 1'b1;
         out_result   <= alu_result;
         out_overflow <= alu_overflow;
         out_op       <= alu_op;
      end else if (out_valid && out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // Overflow history (a new overflow beats a clear) and delivery counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         done_count <= '0;
      end else begin
         if (res_load_c && alu_overflow) begin
            ovf_sticky <= 1'b1;
         end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
         end
         if (out_valid && out_ready) begin
            done_count <= done_count + 8'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [2:0] in_op;
   logic       in_mode;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_op;
   logic       alu_mode;
   logic [3:0] alu_result;
   logic       alu_overflow;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_result;
   logic       out_overflow;
   logic [2:0] out_op;
   logic       ovf_sticky;
   logic       clr_sticky;
   logic [7:0] done_count;

   int total = 0;
   int bad   = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   alu_issue_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_mode(in_mode),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode(alu_mode),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_overflow(out_overflow), .out_op(out_op),
      .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .done_count(done_count)
   );

   // Reference ALU: returns {overflow, result}
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op, input logic m);
      logic [4:0] s;
      logic [3:0] r;
      logic       v;
      logic       lt;
      s = '0; r = '0; v = 1'b0; lt = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0];
                     v = m ? ((a[3] == b[3]) && (r[3] != a[3])) : s[4]; end
         3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0];
                     v = m ? ((a[3] != b[3]) && (r[3] != a[3])) : s[4]; end
         3'd2: begin r = {a[2:0], 1'b0}; v = m ? (a[3] ^ a[2]) : a[3]; end
         3'd3: begin r = {1'b0, a[3:1]}; v = 1'b0; end
         3'd4: begin r = {a[3], a[3:1]}; v = 1'b0; end
         3'd5: begin r = 4'(4'd0 - a); v = m ? (a == 4'b1000) : (a != 4'd0); end
         3'd6: begin lt = m ? ($signed(a) < $signed(b)) : (a < b);
                     r = {2'b00, (a == b), lt}; v = 1'b0; end
         default: begin r = a ^ b ^ 4'b1010; v = 1'b1; end
      endcase
      return {v, r};
   endfunction

   always_comb {alu_overflow, alu_result} = alu_f(alu_a, alu_b, alu_op, alu_mode);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic m);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_mode = m;
   endtask

   // Single accept when the FIFO is known to have space
   task automatic send(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic m);
      drive(a, b, op, m);
      step();
      in_valid = 1'b0;
   endtask

   // Scoreboard: handshakes seen here complete at the following rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0)
               chk("sb_result", 32'({out_op, out_overflow, out_result}), 32'(sb.pop_front()));
         end
         if (in_valid && in_ready)
            sb.push_back({in_op, alu_f(in_a, in_b, in_op, in_mode)});
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc;
      int   sent;
      int   n;
      logic will;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_mode = 1'b0;
      out_ready = 1'b0; clr_sticky = 1'b0;

      // Reset / idle
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_done_count", 32'(done_count), 32'd0);
      chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      rst_n = 1'b1;
      step();

      // Single signed add: -3 + 7 = 4, latency two edges after accept
      out_ready = 1'b1;
      send(4'b1101, 4'b0111, 3'b000, 1'b1);
      chk("lat_e0_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("lat_e1_alu", 32'({alu_a, alu_b, alu_op, alu_mode}), 32'({4'b1101, 4'b0111, 3'b000, 1'b1}));
      chk("lat_e1_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("lat_e2_out_valid", 32'(out_valid), 32'd1);
      chk("add_result", 32'({out_op, out_overflow, out_result}), 32'({3'b000, 1'b0, 4'b0100}));
      step();
      chk("add_done_count", 32'(done_count), 32'd1);
      chk("add_out_valid_clr", 32'(out_valid), 32'd0);

      // Overflow sticky behaviour
      send(4'b0111, 4'b0001, 3'b000, 1'b1);
      step(); step();
      chk("ovf_result", 32'({out_valid, out_overflow, out_result}), 32'({1'b1, 1'b1, 4'b1000}));
      chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
      step();
      send(4'b0001, 4'b0001, 3'b000, 1'b1);
      step(); step();
      chk("noovf_result", 32'({out_valid, out_overflow, out_result}), 32'({1'b1, 1'b0, 4'b0010}));
      chk("ovf_sticky_hold", 32'(ovf_sticky), 32'd1);
      step();
      send(4'b0111, 4'b0001, 3'b000, 1'b1);
      step();
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      chk("clr_vs_set_capture", 32'({out_valid, out_overflow}), 32'({1'b1, 1'b1}));
      chk("clr_vs_set_sticky", 32'(ovf_sticky), 32'd1);
      step();
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      chk("clr_alone_sticky", 32'(ovf_sticky), 32'd0);

      // Backpressure: 8 offered with the consumer stalled, 6 fit
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         drive(4'(acc + 3), 4'(acc), 3'(acc), acc[0]);
         will = in_ready;
         step();
         if (will) acc++;
      end
      chk("bp_accepted", 32'(acc), 32'd6);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (acc < 8) drive(4'(acc + 3), 4'(acc), 3'(acc), acc[0]);
         else in_valid = 1'b0;
         will = in_valid && in_ready;
         step();
         if (will) acc++;
         chk("bp_stream_valid", 32'(out_valid), 32'd1);
      end
      n = 0;
      while (acc < 8 && n < 20) begin
         drive(4'(acc + 3), 4'(acc), 3'(acc), acc[0]);
         will = in_ready;
         step();
         if (will) acc++;
         n++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", 32'(acc), 32'd8);
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 30) begin step(); n++; end
      chk("bp_drained", 32'(sb.size()), 32'd0);

      // Mid-operation reset with three commands in flight
      out_ready = 1'b0;
      send(4'd1, 4'd2, 3'b000, 1'b0);
      send(4'd5, 4'd1, 3'b001, 1'b0);
      send(4'd9, 4'd0, 3'b011, 1'b0);
      chk("mid_out_valid_pre", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_valid_cleared", 32'(out_valid), 32'd0);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      chk("mid_data_cleared", 32'({alu_a, out_result, done_count, ovf_sticky}), 32'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("mid_no_stale", 32'(out_valid), 32'd0);
      end
      send(4'd3, 4'd5, 3'b001, 1'b0);
      step();
      chk("mid_next_e1", 32'(out_valid), 32'd0);
      step();
      chk("mid_next_result", 32'({out_valid, out_op, out_overflow, out_result}),
          32'({1'b1, 3'b001, 1'b1, 4'b1110}));
      step();
      chk("mid_done_count", 32'(done_count), 32'd1);

      // Streaming: 300 random commands with random handshakes, from a fresh reset
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      sent = 0;
      n = 0;
      while (sent < 300 && n < 4000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_a = 4'($urandom); in_b = 4'($urandom); in_op = 3'($urandom); in_mode = 1'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         will = in_valid && in_ready;
         step();
         if (will) sent++;
         n++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 50) begin step(); n++; end
      chk("stream_sent", 32'(sent), 32'd300);
      chk("stream_drained", 32'(sb.size()), 32'd0);
      chk("stream_done_count", 32'(done_count), 32'd44);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
